// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target: FSM states,
// register offsets relative to ADDR, and STATUS bit positions.
package spi_target_pkg;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam logic [31:0] OFF_DATA   = 32'd0;
   localparam logic [31:0] OFF_STATUS = 32'd4;

   localparam int unsigned ST_RXCNT_LSB = 0;
   localparam int unsigned ST_TXCNT_LSB = 8;
   localparam int unsigned ST_RXOVF     = 16;
   localparam int unsigned ST_TXOVF     = 17;
   localparam int unsigned ST_TXUDF     = 18;
   localparam int unsigned ST_CSACT     = 24;

endpackage

// File: rtl/spi_target_fifo.sv
// Byte FIFO with first-word fall-through output; push on full is accepted
// only when a pop happens in the same cycle, pop on empty is ignored.
module spi_target_fifo
   import spi_target_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop_ok;
   logic          push_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with RX/TX byte FIFOs behind a DATA/STATUS register pair.
// Optional SPI_TARGET_IRQ_EN adds a registered OUT_irq output.
module spi_target
   import spi_target_pkg::*;
#(
   parameter logic [31:0] ADDR       = 32'hFF000010,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IN_re,
   input  logic [29:0] IN_raddr,
   output logic [31:0] OUT_rdata,
   output logic        OUT_rbusy,
   output logic        OUT_rvalid,
   input  logic        IN_we,
   input  logic [3:0]  IN_wmask,
   input  logic [29:0] IN_waddr,
   input  logic [31:0] IN_wdata,
   input  logic        IN_SPI_cs,
   input  logic        IN_SPI_clk,
   input  logic        IN_SPI_mosi,
   output logic        OUT_SPI_miso
`ifdef SPI_TARGET_IRQ_EN
   ,
   output logic        OUT_irq
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0] cs_sync, sclk_sync, mosi_sync;
   logic       cs_prev, sclk_prev;
   logic       cs_s, sclk_s, mosi_s;
   logic       cs_fall, cs_rise, sclk_rise, sclk_fall;

   state_t     state, state_next;
   logic       load_first, abort, do_rise, do_fall, byte_done;

   logic [2:0] bit_cnt;
   logic [7:0] rx_shift, tx_shift, rx_din, tx_byte;

   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic          tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]    rx_dout, tx_dout;
   logic [CW-1:0] rx_count, tx_count;

   logic        rx_ovf, tx_ovf, tx_udf;
   logic        rd_data, rd_stat, wr_data, wr_stat;
   logic [31:0] status;
   logic        unused_bits;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_prev   <= 1'b1;
         sclk_prev <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[0], IN_SPI_cs};
         sclk_sync <= {sclk_sync[0], IN_SPI_clk};
         mosi_sync <= {mosi_sync[0], IN_SPI_mosi};
         cs_prev   <= cs_sync[1];
         sclk_prev <= sclk_sync[1];
      end
   end

   assign cs_s      = cs_sync[1];
   assign sclk_s    = sclk_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign cs_fall   = cs_prev & ~cs_s;
   assign cs_rise   = ~cs_prev & cs_s;
   assign sclk_rise = ~sclk_prev & sclk_s;
   assign sclk_fall = sclk_prev & ~sclk_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cs_fall) state_next = SHIFT;
         SHIFT:   if (cs_rise) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A CS rise in SHIFT overrides any SCLK edge seen in the same cycle.
   always_comb begin
      load_first = (state == IDLE) & cs_fall;
      abort      = (state == SHIFT) & cs_rise;
      do_rise    = (state == SHIFT) & ~cs_rise & sclk_rise;
      do_fall    = (state == SHIFT) & ~cs_rise & sclk_fall;
      byte_done  = do_rise & (bit_cnt == 3'd7);
   end

   assign rx_din  = {rx_shift[6:0], mosi_s};
   assign tx_byte = tx_empty ? 8'hFF : tx_dout;

   // tx_shift holds the bits still to be driven; bit 7 goes out on the next fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt      <= '0;
         rx_shift     <= '0;
         tx_shift     <= '0;
         OUT_SPI_miso <= 1'b1;
      end else if (load_first) begin
         bit_cnt      <= '0;
         tx_shift     <= {tx_byte[6:0], 1'b0};
         OUT_SPI_miso <= tx_byte[7];
      end else if (abort) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
      end else if (do_rise) begin
         rx_shift <= rx_din;
         bit_cnt  <= bit_cnt + 3'd1;
         if (byte_done) tx_shift <= tx_byte;
      end else if (do_fall) begin
         OUT_SPI_miso <= tx_shift[7];
         tx_shift     <= {tx_shift[6:0], 1'b0};
      end
   end

   assign rd_data = IN_re & ({IN_raddr, 2'b00} == ADDR + OFF_DATA);
   assign rd_stat = IN_re & ({IN_raddr, 2'b00} == ADDR + OFF_STATUS);
   assign wr_data = IN_we & IN_wmask[0] & ({IN_waddr, 2'b00} == ADDR + OFF_DATA);
   assign wr_stat = IN_we & IN_wmask[2] & ({IN_waddr, 2'b00} == ADDR + OFF_STATUS);

   assign rx_push = byte_done;
   assign rx_pop  = rd_data;
   assign tx_push = wr_data;
   assign tx_pop  = load_first | byte_done;

   spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_din),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(IN_wdata[7:0]),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ovf <= 1'b0;
         tx_ovf <= 1'b0;
         tx_udf <= 1'b0;
      end else begin
         rx_ovf <= (rx_ovf & ~(wr_stat & IN_wdata[ST_RXOVF])) | (rx_push & rx_full & ~rx_pop);
         tx_ovf <= (tx_ovf & ~(wr_stat & IN_wdata[ST_TXOVF])) | (tx_push & tx_full & ~tx_pop);
         tx_udf <= (tx_udf & ~(wr_stat & IN_wdata[ST_TXUDF])) | (tx_pop & tx_empty);
      end
   end

   always_comb begin
      status                      = '0;
      status[ST_RXCNT_LSB +: 5]   = 5'(rx_count);
      status[ST_TXCNT_LSB +: 5]   = 5'(tx_count);
      status[ST_RXOVF]            = rx_ovf;
      status[ST_TXOVF]            = tx_ovf;
      status[ST_TXUDF]            = tx_udf;
      status[ST_CSACT]            = ~cs_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         OUT_rvalid <= 1'b0;
         OUT_rdata  <= '0;
      end else begin
         OUT_rvalid <= rd_data | rd_stat;
         if (rd_data)      OUT_rdata <= rx_empty ? 32'h100 : {24'h0, rx_dout};
         else if (rd_stat) OUT_rdata <= status;
         else              OUT_rdata <= '0;
      end
   end

   assign OUT_rbusy = 1'b0;

`ifdef SPI_TARGET_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) OUT_irq <= 1'b0;
      else     OUT_irq <= ~rx_empty | rx_ovf | tx_ovf | tx_udf;
   end
`endif

   assign unused_bits = ^{IN_wdata[31:19], IN_wdata[15:8], IN_wmask[3], IN_wmask[1], rx_shift[7]};

endmodule

// File: tb/tb_spi_target.sv
// Randomized bench for spi_target: acts as the SPI initiator and bus master,
// predicting every response from a queue-based model of the register map.
module tb_spi_target;

   localparam logic [31:0] ADDR = 32'hFF000010;
   localparam int D = 8;

   logic        clk, rst;
   logic        IN_re, IN_we;
   logic [29:0] IN_raddr, IN_waddr;
   logic [31:0] OUT_rdata, IN_wdata;
   logic        OUT_rbusy, OUT_rvalid;
   logic [3:0]  IN_wmask;
   logic        IN_SPI_cs, IN_SPI_clk, IN_SPI_mosi, OUT_SPI_miso;
`ifdef SPI_TARGET_IRQ_EN
   logic        unused_irq;
`endif

   spi_target #(.ADDR(ADDR), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .IN_re(IN_re), .IN_raddr(IN_raddr), .OUT_rdata(OUT_rdata),
      .OUT_rbusy(OUT_rbusy), .OUT_rvalid(OUT_rvalid),
      .IN_we(IN_we), .IN_wmask(IN_wmask), .IN_waddr(IN_waddr), .IN_wdata(IN_wdata),
      .IN_SPI_cs(IN_SPI_cs), .IN_SPI_clk(IN_SPI_clk), .IN_SPI_mosi(IN_SPI_mosi),
      .OUT_SPI_miso(OUT_SPI_miso)
`ifdef SPI_TARGET_IRQ_EN
      , .OUT_irq(unused_irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err = 0;

   // Model state
   logic [7:0]  rxq[$];
   logic [7:0]  txq[$];
   logic        rxo, txo, txu, cs_act;
   logic [7:0]  cur;
   logic        exp_valid;
   logic [31:0] exp_data;
   logic        started;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = '0;
      s[4:0]   = 5'(rxq.size());
      s[12:8]  = 5'(txq.size());
      s[16]    = rxo;
      s[17]    = txo;
      s[18]    = txu;
      s[24]    = cs_act;
      return s;
   endfunction

   task automatic m_reset();
      rxq.delete();
      txq.delete();
      rxo = 1'b0; txo = 1'b0; txu = 1'b0; cs_act = 1'b0;
      cur = 8'h00;
      exp_valid = 1'b0;
      exp_data = '0;
   endtask

   task automatic m_load();
      if (txq.size() > 0) cur = txq.pop_front();
      else begin
         cur = 8'hFF;
         txu = 1'b1;
      end
   endtask

   task automatic m_rx(input logic [7:0] b);
      if (rxq.size() < D) rxq.push_back(b);
      else rxo = 1'b1;
   endtask

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      if (a == ADDR && m[0]) begin
         if (txq.size() < D) txq.push_back(d[7:0]);
         else txo = 1'b1;
      end
      if (a == ADDR + 4 && m[2]) begin
         if (d[16]) rxo = 1'b0;
         if (d[17]) txo = 1'b0;
         if (d[18]) txu = 1'b0;
      end
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] got);
      logic        hit;
      logic [31:0] e;
      hit = 1'b0;
      e = '0;
      if (a == ADDR) begin
         hit = 1'b1;
         if (rxq.size() > 0) e = {24'h0, rxq.pop_front()};
         else e = 32'h100;
      end else if (a == ADDR + 4) begin
         hit = 1'b1;
         e = m_status();
      end
      IN_re = 1'b1;
      IN_raddr = a[31:2];
      tick();
      IN_re = 1'b0;
      exp_valid = hit;
      exp_data = e;
      got = OUT_rdata;
      tick();
      exp_valid = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      IN_we = 1'b1;
      IN_waddr = a[31:2];
      IN_wdata = d;
      IN_wmask = m;
      tick();
      IN_we = 1'b0;
      m_write(a, d, m);
   endtask

   task automatic cs_lower();
      IN_SPI_cs = 1'b0;
      m_load();
      cs_act = 1'b1;
      ticks(6);
   endtask

   task automatic cs_raise();
      ticks(4);
      IN_SPI_cs = 1'b1;
      IN_SPI_mosi = 1'b0;
      cs_act = 1'b0;
      ticks(6);
   endtask

   task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < n; i++) begin
         IN_SPI_mosi = mo[7-i];
         ticks(6);
         check("miso", 32'(OUT_SPI_miso), 32'(cur[7-i]));
         mi[7-i] = OUT_SPI_miso;
         IN_SPI_clk = 1'b1;
         if (i == 7) begin
            m_rx(mo);
            m_load();
         end
         ticks(6);
         IN_SPI_clk = 1'b0;
      end
   endtask

   task automatic drain();
      logic [31:0] g;
      while (rxq.size() > 0) bus_read(ADDR, g);
   endtask

   // Per-cycle comparison of the bus response against the model
   initial begin
      forever begin
         @(negedge clk);
         if (started && !rst) begin
            check("rbusy", 32'(OUT_rbusy), 32'd0);
            check("rvalid", 32'(OUT_rvalid), 32'(exp_valid));
            if (exp_valid) check("rdata", OUT_rdata, exp_data);
         end
      end
   end

   initial begin
      logic [31:0] got;
      logic [7:0]  mi;
      int          op, nb, nbits;
      logic        abrt;
      logic [31:0] a;

      started = 1'b0;
      rst = 1'b0;
      IN_re = 1'b0; IN_we = 1'b0; IN_raddr = '0; IN_waddr = '0;
      IN_wdata = '0; IN_wmask = '0;
      IN_SPI_cs = 1'b1; IN_SPI_clk = 1'b0; IN_SPI_mosi = 1'b0;
      m_reset();
      #1 rst = 1'b1;
      #1;
      check("rst_miso", 32'(OUT_SPI_miso), 32'd1);
      check("rst_rvalid", 32'(OUT_rvalid), 32'd0);
      check("rst_rdata", OUT_rdata, 32'd0);
      ticks(3);
      rst = 1'b0;
      ticks(2);
      started = 1'b1;
      bus_read(ADDR + 4, got);
      check("rst_status", got, 32'd0);

      // A5 out, 3C in
      bus_write(ADDR, 32'hA5, 4'b0001);
      cs_lower();
      spi_bits(8'h3C, 8, mi);
      cs_raise();
      check("a5_miso", 32'(mi), 32'hA5);
      bus_read(ADDR, got);
      check("3c_data", got, 32'h3C);
      bus_read(ADDR + 4, got);
      check("3c_rxcount", 32'(got[4:0]), 32'd0);
      bus_write(ADDR + 4, 32'h70000, 4'b0100);

      // Underflow and W1C clear
      cs_lower();
      bus_read(ADDR + 4, got);
      check("udf_flag", 32'(got[18]), 32'd1);
      check("cs_active", 32'(got[24]), 32'd1);
      spi_bits(8'h5C, 8, mi);
      check("udf_miso", 32'(mi), 32'hFF);
      cs_raise();
      bus_write(ADDR + 4, 32'h40000, 4'b0100);
      bus_read(ADDR + 4, got);
      check("udf_clear", 32'(got[18]), 32'd0);
      drain();

      // RX overflow
      bus_write(ADDR + 4, 32'h70000, 4'b0100);
      cs_lower();
      for (int k = 0; k < D + 1; k++) spi_bits(8'(8'h40 + k * 3), 8, mi);
      cs_raise();
      bus_read(ADDR + 4, got);
      check("ovf_rxcount", 32'(got[4:0]), 32'(D));
      check("ovf_flag", 32'(got[16]), 32'd1);
      for (int k = 0; k < D; k++) begin
         bus_read(ADDR, got);
         check("ovf_order", got, 32'(8'h40 + k * 3));
      end
      bus_read(ADDR, got);
      check("ovf_empty", got, 32'h100);

      // Aborted partial byte
      cs_lower();
      spi_bits(8'hF0, 4, mi);
      cs_raise();
      cs_lower();
      spi_bits(8'h81, 8, mi);
      cs_raise();
      bus_read(ADDR, got);
      check("abort_data", got, 32'h81);
      bus_read(ADDR, got);
      check("abort_empty", got, 32'h100);

      // DATA write coinciding with the 8th SCLK rise that pops the last TX byte
      bus_write(ADDR + 4, 32'h70000, 4'b0100);
      bus_write(ADDR, 32'h11, 4'b0001);
      bus_write(ADDR, 32'h22, 4'b0001);
      cs_lower();
      spi_bits(8'h6B, 7, mi);
      IN_SPI_mosi = 1'b1;
      ticks(6);
      check("race_miso", 32'(OUT_SPI_miso), 32'(cur[0]));
      IN_SPI_clk = 1'b1;
      ticks(2);
      IN_we = 1'b1; IN_waddr = ADDR[31:2]; IN_wdata = 32'h33; IN_wmask = 4'b0001;
      tick();
      IN_we = 1'b0;
      m_rx(8'h6B);
      m_load();
      m_write(ADDR, 32'h33, 4'b0001);
      ticks(3);
      IN_SPI_clk = 1'b0;
      cs_raise();
      bus_read(ADDR + 4, got);
      check("race_txcount", 32'(got[12:8]), 32'd1);
      check("race_flags", 32'(got[18:16]), 32'd0);
      drain();

      // Asynchronous reset mid-byte
      cs_lower();
      spi_bits(8'hC3, 3, mi);
      #1 rst = 1'b1;
      #1;
      check("arst_miso", 32'(OUT_SPI_miso), 32'd1);
      check("arst_rvalid", 32'(OUT_rvalid), 32'd0);
      check("arst_rdata", OUT_rdata, 32'd0);
      IN_SPI_cs = 1'b1; IN_SPI_clk = 1'b0; IN_SPI_mosi = 1'b0;
      m_reset();
      ticks(3);
      rst = 1'b0;
      ticks(4);
      bus_write(ADDR, 32'h5A, 4'b0001);
      cs_lower();
      spi_bits(8'h96, 8, mi);
      cs_raise();
      check("arst_miso_byte", 32'(mi), 32'h5A);
      bus_read(ADDR, got);
      check("arst_data", got, 32'h96);

      // Randomized traffic
      for (int t = 0; t < 80; t++) begin
         op = $urandom_range(0, 6);
         case (op)
            0: bus_write(ADDR, $urandom, 4'($urandom_range(0, 15)));
            1: bus_read(ADDR, got);
            2: bus_read(ADDR + 4, got);
            3: bus_write(ADDR + 4, 32'($urandom_range(0, 7)) << 16, 4'($urandom_range(0, 15)));
            4, 5: begin
               nb = $urandom_range(1, 3);
               abrt = ($urandom_range(0, 3) == 0);
               cs_lower();
               for (int b = 0; b < nb; b++) begin
                  nbits = (abrt && b == nb - 1) ? $urandom_range(1, 7) : 8;
                  spi_bits(8'($urandom), nbits, mi);
               end
               cs_raise();
            end
            default: begin
               a = ($urandom_range(0, 1) == 0) ? ADDR + 8 : ADDR - 4;
               bus_read(a, got);
               bus_write(a, $urandom, 4'b1111);
            end
         endcase
      end
      bus_read(ADDR + 4, got);
      drain();
      bus_read(ADDR, got);
      check("final_empty", got, 32'h100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter ADDR, default 32'hFF000010, byte address of DATA register; STATUS is at ADDR+4.
REQ-002 Parameter FIFO_DEPTH, default 8, byte entries per RX and TX FIFO; power of two, 2..16.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 IN_re in 1 read strobe; IN_raddr in 30 word address; OUT_rdata out 32 read data; OUT_rbusy out 1 busy; OUT_rvalid out 1 read data valid.
REQ-006 IN_we in 1 write strobe; IN_wmask in 4 byte enables; IN_waddr in 30 word address; IN_wdata in 32 write data.
REQ-007 IN_SPI_cs in 1 chip select, active low; IN_SPI_clk in 1 SCLK from initiator; IN_SPI_mosi in 1 initiator data; OUT_SPI_miso out 1 target data.

Function
REQ-008 SPI mode 0, MSB first, 8-bit frames; MOSI sampled on SCLK rising edge; MISO changes only on SCLK falling edge or CS falling edge.
REQ-009 cs, clk and mosi each pass through a 2-flop synchronizer; edges are detected on synchronized values; the initiator guarantees an SCLK half-period of at least 3 clk cycles.
REQ-010 FSM states IDLE, SHIFT; IDLE->SHIFT on synchronized CS fall; SHIFT->IDLE on CS rise; SCLK edges in IDLE are ignored.
REQ-011 On CS fall: bit counter = 0; pop TX FIFO into TX shift register and drive its bit 7 on MISO; if TX empty, load 8'hFF and set txUnderflow.
REQ-012 Each SCLK rise in SHIFT: shift synchronized MOSI into RX shift register, increment 3-bit bit counter (wraps 7->0).
REQ-013 On the 8th rise: push RX byte into RX FIFO, or drop it and set rxOverflow if full; pop next TX byte as in REQ-011 (same 8'hFF/underflow rule).
REQ-014 Each SCLK fall in SHIFT: MISO = next TX shift register bit.
REQ-015 CS rise mid-byte: discard partial RX byte, clear bit counter; popped TX byte is lost; no flag set.
REQ-016 Read latency 1 cycle: OUT_rvalid=1 the cycle after IN_re with {IN_raddr,2'b0} equal to ADDR or ADDR+4; otherwise 0; OUT_rbusy is constant 0.
REQ-017 DATA read: RX non-empty -> {23'b0,1'b0,byte}, pop; RX empty -> 32'h100, no pop.
REQ-018 DATA write with IN_wmask[0]: push IN_wdata[7:0] to TX FIFO, or drop and set txOverflow if full; without wmask[0] no effect.
REQ-019 STATUS read: [4:0] rxCount, [12:8] txCount, [16] rxOverflow, [17] txOverflow, [18] txUnderflow, [24] CS active (synchronized CS low); other bits 0; no side effects.
REQ-020 STATUS write with IN_wmask[2]: IN_wdata bits 16..18 that are 1 clear the matching sticky flag (W1C); a same-cycle set wins over clear.
REQ-021 Same-cycle push and pop on one FIFO both take effect; count unchanged; pop on full and push on empty are legal in that cycle.

Reset
REQ-022 Reset: FIFOs empty, pointers 0, flags 0, FSM IDLE, shift registers 0, bit counter 0, OUT_SPI_miso=1, OUT_rvalid=0, OUT_rdata=0, synchronizer flops 1 (cs), 0 (clk, mosi).
REQ-023 Reset asserted mid-transfer aborts the frame; after release the block waits in IDLE for a fresh CS fall.

Configuration
REQ-024 Macro SPI_TARGET_IRQ_EN: defined -> output port OUT_irq (1 bit, registered) = RX non-empty OR any sticky flag set, reset 0; undefined -> port and logic absent, otherwise identical.

Structure
REQ-025 Package spi_target_pkg holds the FSM state enum, register offsets (DATA=0, STATUS=4) and STATUS bit positions.
REQ-026 Sub-module spi_target_fifo (parameterized depth, 8-bit data, push/pop/full/empty/count), instantiated twice for RX and TX.

Verification
REQ-027 Write DATA 8'hA5, initiator sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; DATA read returns 32'h3C; STATUS rxCount 0.
REQ-028 CS fall with TX empty -> MISO 8'hFF, STATUS[18]=1; STATUS write 32'h40000 with wmask 4'b0100 -> STATUS[18]=0.
REQ-029 Initiator sends FIFO_DEPTH+1 bytes without reads -> rxCount=FIFO_DEPTH, STATUS[16]=1, DATA reads return the first FIFO_DEPTH bytes in order, then 32'h100.
REQ-030 CS rises after 4 SCLK edges of 8'hF0, then full 8'h81 -> only 8'h81 in RX FIFO.
REQ-031 DATA write on the same cycle the 8th SCLK rise pops the last TX byte -> txCount ends 1, no txOverflow/txUnderflow.
REQ-032 rst pulsed mid-byte (async, between clk edges) -> all outputs at reset values immediately; next full frame received correctly.
